mul_seq: RTL and testbench

Sequential radix-2 shift-add multiplier for the integer arithmetic unit; the multiplication counterpart of the iterative divider. Accepts an operand pair on a start/finish handshake, iterates one multiplier bit per cycle and returns a 2·WIDTH-bit product split into high and low words. It can either use a private adder or borrow the shared WIDTH+1-bit adder that the arithmetic unit already exports.

---
 rtl/arith_pkg.sv | 13 +
 rtl/mul_seq.sv | 134 +++++++++++++
 tb/tb_mul_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared integer-arithmetic definitions: iterative-unit FSM encoding and
// cycle-counter width, common to the sequential multiplier and divider.
package arith_pkg;

  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier, one multiplier bit per cycle.
// Optional build macro MUL_ZERO_SKIP_EN: zero operands finish in one cycle.
module mul_seq
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RSHARE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_a,
  input  logic               signed_b,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [WIDTH-1:0]   product_lo,
  output logic [WIDTH-1:0]   product_hi,
  output logic               finish,
  output logic [WIDTH:0]     addA,
  output logic [WIDTH:0]     addB,
  output logic               addC,
  input  logic [WIDTH:0]     addRes
);

  localparam int unsigned PW = 2 * WIDTH;

  // The cycle counter is shared with the divider and only holds up to 127.
  if (WIDTH < 2 || WIDTH > 127) begin : g_bad_width
    $error("mul_seq: WIDTH must be in 2..127");
  end

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic               neg_a_c;
  logic               neg_b_c;
  logic [WIDTH-1:0]   mag_a_c;
  logic [WIDTH-1:0]   mag_b_c;
  logic [WIDTH:0]     add_a_c;
  logic [WIDTH:0]     add_b_c;
  logic [WIDTH:0]     sum_c;
  logic [PW-1:0]      raw_c;
  logic [PW-1:0]      prod_c;

  // Operand magnitudes and result sign, evaluated on the accepting edge.
  always_comb begin
    neg_a_c = signed_a & multiplicand[WIDTH-1];
    neg_b_c = signed_b & multiplier[WIDTH-1];
    mag_a_c = neg_a_c ? (-multiplicand) : multiplicand;
    mag_b_c = neg_b_c ? (-multiplier) : multiplier;
  end

  always_comb begin
    add_a_c = {1'b0, acc};
    add_b_c = mplr[0] ? {1'b0, mcand} : '0;
    raw_c   = {acc, mplr};
    prod_c  = neg ? (-raw_c) : raw_c;
  end

  // Shared-adder operands are only driven while this unit owns the adder.
  if (RSHARE != 0) begin : g_shared
    assign addA  = (state == ST_RUN) ? add_a_c : '0;
    assign addB  = (state == ST_RUN) ? add_b_c : '0;
    assign sum_c = addRes;
  end else begin : g_private
    logic unused_add_res;
    assign unused_add_res = ^addRes;
    assign addA  = '0;
    assign addB  = '0;
    assign sum_c = add_a_c + add_b_c;
  end

  assign addC = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      finish     <= 1'b1;
      product_lo <= '0;
      product_hi <= '0;
      acc        <= '0;
      mplr       <= '0;
      mcand      <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= mag_a_c;
            mplr   <= mag_b_c;
            acc    <= '0;
            neg    <= neg_a_c ^ neg_b_c;
            cnt    <= CNT_W'(WIDTH);
            finish <= 1'b0;
`ifdef MUL_ZERO_SKIP_EN
            if (mag_a_c == '0 || mag_b_c == '0) begin
              mplr  <= '0;
              state <= ST_FIX;
            end else begin
              state <= ST_RUN;
            end
`else
            state  <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          // Product bits shift down from acc into the vacated multiplier bits.
          acc  <= sum_c[WIDTH:1];
          mplr <= {sum_c[0], mplr[WIDTH-1:1]};
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          product_hi <= prod_c[PW-1:WIDTH];
          product_lo <= prod_c[WIDTH-1:0];
          finish     <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: private-adder and shared-adder instances run
// side by side on identical stimulus and are checked against fixed values.
module tb_mul_seq;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_a;
  logic          signed_b;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;

  logic [W-1:0]  lo0, hi0, lo1, hi1;
  logic          finish0, finish1;
  logic [W:0]    add_a0, add_b0, add_a1, add_b1;
  logic          add_c0, add_c1;
  logic [W:0]    add_res1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Combinational shared adder owned by the bench.
  assign add_res1 = add_a1 + add_b1 + {{W{1'b0}}, add_c1};

  mul_seq #(.WIDTH(W), .RSHARE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .signed_a(signed_a), .signed_b(signed_b),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product_lo(lo0), .product_hi(hi0), .finish(finish0),
    .addA(add_a0), .addB(add_b0), .addC(add_c0), .addRes('0)
  );

  mul_seq #(.WIDTH(W), .RSHARE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .signed_a(signed_a), .signed_b(signed_b),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product_lo(lo1), .product_hi(hi1), .finish(finish1),
    .addA(add_a1), .addB(add_b1), .addC(add_c1), .addRes(add_res1)
  );

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sa, input logic sb);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    signed_a     = sa;
    signed_b     = sb;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after acceptance until both instances report finish.
  task automatic wait_done(output int lat);
    lat = 0;
    while ((finish0 !== 1'b1 || finish1 !== 1'b1) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sa, input logic sb,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input int exp_lat);
    int lat;
    launch(a, b, sa, sb);
    checks++;
    if (finish0 !== 1'b0 || finish1 !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: finish0=%b finish1=%b required 0", name, finish0, finish1);
    end
    wait_done(lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (hi0 !== exp_hi || lo0 !== exp_lo) begin
      errors++;
      $display("FAIL %s private: got %h_%h required %h_%h", name, hi0, lo0, exp_hi, exp_lo);
    end
    checks++;
    if (hi1 !== exp_hi || lo1 !== exp_lo) begin
      errors++;
      $display("FAIL %s shared: got %h_%h required %h_%h", name, hi1, lo1, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    signed_a = 1'b0;
    signed_b = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (finish0 !== 1'b1 || finish1 !== 1'b1 || lo0 !== '0 || hi0 !== '0 || lo1 !== '0 || hi1 !== '0) begin
      errors++;
      $display("FAIL reset_outputs: finish=%b/%b p0=%h_%h p1=%h_%h required 1/1 zeros",
               finish0, finish1, hi0, lo0, hi1, lo1);
    end
    checks++;
    if (add_a0 !== '0 || add_b0 !== '0 || add_c0 !== 1'b0 || add_a1 !== '0 || add_b1 !== '0 || add_c1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_adder: a0=%h b0=%h c0=%b a1=%h b1=%h c1=%b required zeros",
               add_a0, add_b0, add_c0, add_a1, add_b1, add_c1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_check("u_7x6", 32'd7, 32'd6, 1'b0, 1'b0, 32'h0, 32'h0000002A, W + 1);
    run_check("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, W + 1);
  endtask

  task automatic test_signed();
    run_check("s_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, W + 1);
    run_check("s_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 32'h1, W + 1);
    run_check("s_minxmin", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h0, W + 1);
    run_check("mix_a", 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, W + 1);
    run_check("mix_b", 32'd3, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, W + 1);
  endtask

  task automatic test_reset_mid_run();
    launch(32'd9, 32'd9, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (finish0 !== 1'b1 || finish1 !== 1'b1 || lo0 !== '0 || hi0 !== '0 || lo1 !== '0 || hi1 !== '0) begin
      errors++;
      $display("FAIL mid_reset: finish=%b/%b p0=%h_%h p1=%h_%h required 1/1 zeros",
               finish0, finish1, hi0, lo0, hi1, lo1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_busy_start();
    int lat;
    run_check("busy_pre", 32'd5, 32'd5, 1'b0, 1'b0, 32'h0, 32'd25, W + 1);
    launch(32'd3, 32'd4, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    multiplicand = 32'd100;
    multiplier   = 32'd100;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (finish0 !== 1'b0 || lo0 !== 32'd25 || lo1 !== 32'd25 || hi0 !== '0 || hi1 !== '0) begin
      errors++;
      $display("FAIL busy_hold: finish=%b lo0=%h lo1=%h required 0 00000019", finish0, lo0, lo1);
    end
    wait_done(lat);
    lat = lat + 6;
    checks++;
    if (lat !== W + 1 || lo0 !== 32'd12 || lo1 !== 32'd12 || hi0 !== '0 || hi1 !== '0) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d lo0=%h lo1=%h required %0d 0000000c", lat, lo0, lo1, W + 1);
    end
  endtask

  task automatic test_zero();
`ifdef MUL_ZERO_SKIP_EN
    run_check("zero_a", 32'd0, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 1);
    run_check("zero_b", 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1);
`else
    run_check("zero_a", 32'd0, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, W + 1);
    run_check("zero_b", 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 32'h0, 32'h0, W + 1);
`endif
  endtask

  task automatic test_back_to_back();
    run_check("b2b_1", 32'd1000, 32'd1000, 1'b0, 1'b0, 32'h0, 32'h000F4240, W + 1);
    run_check("b2b_2", 32'h00010000, 32'h00010000, 1'b0, 1'b0, 32'h00000001, 32'h0, W + 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_reset_mid_run();
    test_busy_start();
    test_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
